// File: rtl/vga_pattern_gen.sv
// Purpose : test-pattern source for the 1920x1080@60 VGA output stage; key press selects the next pattern at a frame boundary.
// Latency : PIX_GRB is registered, 1 CLK after CC/LL; MODE and box change only on the frame-end cycle.
// Backpressure: none; pixel stream follows the timing counters every clock, key requests are held until the frame end.
//
// Ports:
//   CLK        pixel clock (148.5 MHz)
//   RESET      synchronous, active-low reset
//   CC, LL     horizontal pixel / vertical line counters from the timing stage
//   KEY_IN     debounced key level from another clock domain; rising edge = next pattern
//   PIX_GRB    registered pixel colour {G,R,B}
//   MODE       currently displayed pattern
//   FRAME_TICK one-cycle pulse after the last pixel clock of each frame
module vga_pattern_gen #(
  parameter int H_ACTIVE  = 1920,
  parameter int V_ACTIVE  = 1080,
  parameter int H_TOTAL   = 2200,
  parameter int V_TOTAL   = 1125,
  parameter int BAR_W     = 240,
  parameter int BAR_H     = 135,
  parameter int BOX       = 128,
  parameter int STEP      = 4,
  parameter int NUM_MODES = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] CC,
  input  logic [10:0] LL,
  input  logic        KEY_IN,
  output logic [2:0]  PIX_GRB,
  output logic [2:0]  MODE,
  output logic        FRAME_TICK
);

  localparam logic [2:0] MODE_VBAR  = 3'd0;
  localparam logic [2:0] MODE_HBAR  = 3'd1;
  localparam logic [2:0] MODE_XOR   = 3'd2;
  localparam logic [2:0] MODE_CHECK = 3'd3;
  localparam logic [2:0] MODE_BOX   = 3'd4;
  localparam logic [2:0] MODE_LAST  = 3'(NUM_MODES - 1);

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [11:0] H_END  = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_END  = 11'(V_TOTAL - 1);
  localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - BOX);
  localparam logic [11:0] X_TURN = 12'(H_ACTIVE - BOX - STEP);
  localparam logic [11:0] X_STEP = 12'(STEP);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX);
  localparam logic [10:0] Y_TURN = 11'(V_ACTIVE - BOX - STEP);
  localparam logic [10:0] Y_STEP = 11'(STEP);

  // Key synchroniser and edge detector
  logic key_sync1;
  logic key_sync2;
  logic key_prev;
  logic key_edge;
  logic pending;

  // Bouncing box state; dx/dy = 1 means moving towards larger coordinates
  logic [11:0] box_x;
  logic [10:0] box_y;
  logic        box_dx;
  logic        box_dy;

  logic        frame_end;
  logic [11:0] vbar_idx;
  logic [10:0] hbar_idx;
  logic [2:0]  vcode;
  logic [2:0]  hcode;
  logic [12:0] box_x_end;
  logic [11:0] box_y_end;
  logic        in_box;
  logic [2:0]  pix_next;

  assign key_edge  = key_sync2 & ~key_prev;
  assign frame_end = (CC == H_END) && (LL == V_END);

  assign vbar_idx = CC / 12'(BAR_W);
  assign hbar_idx = LL / 11'(BAR_H);
  assign vcode    = (vbar_idx > 12'd7) ? 3'd0 : 3'(12'd7 - vbar_idx);
  assign hcode    = (hbar_idx > 11'd7) ? 3'd0 : 3'(11'd7 - hbar_idx);

  // One extra bit so X+BOX / Y+BOX can never wrap
  assign box_x_end = {1'b0, box_x} + 13'(BOX);
  assign box_y_end = {1'b0, box_y} + 12'(BOX);
  assign in_box    = (CC >= box_x) && ({1'b0, CC} < box_x_end) &&
                     (LL >= box_y) && ({1'b0, LL} < box_y_end);

  always_comb begin
    pix_next = 3'd0;
    if ((CC < H_ACT) && (LL < V_ACT)) begin
      case (MODE)
        MODE_VBAR:  pix_next = vcode;
        MODE_HBAR:  pix_next = hcode;
        MODE_XOR:   pix_next = vcode ^ hcode;
        MODE_CHECK: pix_next = (CC[6] ^ LL[6]) ? 3'd7 : 3'd0;
        MODE_BOX:   pix_next = in_box ? 3'd7 : 3'd1;
        default:    pix_next = 3'd0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      key_sync1  <= 1'b0;
      key_sync2  <= 1'b0;
      key_prev   <= 1'b0;
      pending    <= 1'b0;
      MODE       <= MODE_VBAR;
      FRAME_TICK <= 1'b0;
      PIX_GRB    <= 3'd0;
      box_x      <= 12'd0;
      box_y      <= 11'd0;
      box_dx     <= 1'b1;
      box_dy     <= 1'b1;
    end else begin
      key_sync1  <= KEY_IN;
      key_sync2  <= key_sync1;
      key_prev   <= key_sync2;
      FRAME_TICK <= frame_end;
      PIX_GRB    <= pix_next;

      // A request consumed at the frame end is replaced by an edge seen in
      // that same cycle, so a press landing exactly on the boundary survives.
      if (frame_end && pending) begin
        MODE    <= (MODE == MODE_LAST) ? MODE_VBAR : MODE + 3'd1;
        pending <= key_edge;
      end else if (key_edge) begin
        pending <= 1'b1;
      end

      // Box decision uses the MODE in effect before this tick's advance.
      if (frame_end && (MODE == MODE_BOX)) begin
        if (box_dx) begin
          if (box_x == X_TURN) begin
            box_x  <= X_MAX;
            box_dx <= 1'b0;
          end else begin
            box_x <= box_x + X_STEP;
          end
        end else begin
          if (box_x == X_STEP) begin
            box_x  <= 12'd0;
            box_dx <= 1'b1;
          end else begin
            box_x <= box_x - X_STEP;
          end
        end

        if (box_dy) begin
          if (box_y == Y_TURN) begin
            box_y  <= Y_MAX;
            box_dy <= 1'b0;
          end else begin
            box_y <= box_y + Y_STEP;
          end
        end else begin
          if (box_y == Y_STEP) begin
            box_y  <= 11'd0;
            box_dy <= 1'b1;
          end else begin
            box_y <= box_y - Y_STEP;
          end
        end
      end
    end
  end

endmodule
